// File: rtl/gate_truth_table_checker.sv
// Self-test driver for a two-input gate unit (AND/OR/NOR/XOR/NAND outputs).
// Sweeps {a,b} = 00,01,10,11, holds each vector SETTLE_CYCLES cycles, then
// compares the unit's outputs against the ideal truth table for one cycle.
// Reports pass, a sticky per-gate mismatch mask and the first failing vector.
// Optional build macro GTC_STOP_ON_FAIL_EN: end the sweep at the first
// mismatching vector instead of testing all four.
module gate_truth_table_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       nor_in,
  input  logic       xor_in,
  input  logic       nand_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] fail_mask,
  output logic [1:0] first_fail_vec
);

`ifdef GTC_STOP_ON_FAIL_EN
  localparam bit StopOnFail = 1'b1;
`else
  localparam bit StopOnFail = 1'b0;
`endif

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [4:0] mask_q, mask_d;
  logic [1:0] first_q, first_d;
  logic [4:0] expected, observed, mismatch;

  // Ideal truth table for the vector currently applied (bit order matches fail_mask)
  always_comb begin
    expected = {~(vec_q[1] & vec_q[0]), vec_q[1] ^ vec_q[0], ~(vec_q[1] | vec_q[0]),
                vec_q[1] | vec_q[0], vec_q[1] & vec_q[0]};
    observed = {nand_in, xor_in, nor_in, or_in, and_in};
    mismatch = expected ^ observed;
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      first_q <= first_d;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StSettle;
      StSettle: if (cnt_q == SettleLast) state_d = StCheck;
      StCheck: begin
        if (vec_q == 2'd3 || (StopOnFail && mismatch != '0)) state_d = StDone;
        else state_d = StSettle;
      end
      StDone:   state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mask_d  = mask_q;
    first_d = first_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          vec_d   = '0;
          cnt_d   = '0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          mask_d  = '0;
          first_d = '0;
        end
      end
      StSettle: cnt_d = cnt_q + 8'd1;
      StCheck: begin
        mask_d = mask_q | mismatch;
        if (mask_q == '0 && mismatch != '0) first_d = vec_q;
        if (state_d == StDone) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (mask_d == '0);
          a_d    = 1'b0;
          b_d    = 1'b0;
        end else begin
          vec_d = vec_q + 2'd1;
          a_d   = vec_d[1];
          b_d   = vec_d[0];
          cnt_d = '0;
        end
      end
      StDone: ;
    endcase
  end

  assign a_out          = a_q;
  assign b_out          = b_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_mask      = mask_q;
  assign first_fail_vec = first_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker with a fault-injectable ideal gate model.
module tb_gate_truth_table_checker;
  localparam int unsigned Settle = 2;
  localparam int PerVec = Settle + 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic a_out, b_out, and_in, or_in, nor_in, xor_in, nand_in;
  logic busy, done, pass;
  logic [4:0] fail_mask;
  logic [1:0] first_fail_vec;
  int fault = 0;  // 0 ideal, 1 xor stuck at 0, 2 and stuck at 1
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  assign and_in  = (fault == 2) ? 1'b1 : (a_out & b_out);
  assign or_in   = a_out | b_out;
  assign nor_in  = ~(a_out | b_out);
  assign xor_in  = (fault == 1) ? 1'b0 : (a_out ^ b_out);
  assign nand_in = ~(a_out & b_out);

  gate_truth_table_checker #(.SETTLE_CYCLES(Settle)) dut (
    .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out),
    .and_in(and_in), .or_in(or_in), .nor_in(nor_in), .xor_in(xor_in), .nand_in(nand_in),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
    .first_fail_vec(first_fail_vec)
  );

  typedef struct {
    int         fault;
    int         busy_cycles;
    logic       pass;
    logic [4:0] mask;
    logic [1:0] first;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start and follow one sweep; optionally re-pulse start at busy cycle repulse_at.
  task automatic sweep(input string tag, input int exp_busy, input int repulse_at);
    int n = 0;
    int seq_err = 0;
    int v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " accept_clear"}, {pass, fail_mask, 2'b00}, 8'h00);
    while (busy && n < 200) begin
      v = n / PerVec;
      if (a_out !== v[1] || b_out !== v[0] || done !== 1'b0) seq_err++;
      n++;
      start = (n == repulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " ab_seq_errors"}, 8'(seq_err), 8'd0);
    chk({tag, " busy_cycles"}, 8'(n), 8'(exp_busy));
    chk({tag, " done_pulse"}, {7'd0, done}, 8'd1);
    chk({tag, " ab_after"}, {6'd0, a_out, b_out}, 8'd0);
    @(negedge clk);
    chk({tag, " done_clear"}, {6'd0, done, busy}, 8'd0);
  endtask

  vec_t tab[4];

  initial begin
`ifdef GTC_STOP_ON_FAIL_EN
    tab[0] = '{0, 4 * PerVec, 1'b1, 5'b00000, 2'b00};
    tab[1] = '{1, 2 * PerVec, 1'b0, 5'b01000, 2'b01};
    tab[2] = '{2, 1 * PerVec, 1'b0, 5'b00001, 2'b00};
    tab[3] = '{0, 4 * PerVec, 1'b1, 5'b00000, 2'b00};
`else
    tab[0] = '{0, 4 * PerVec, 1'b1, 5'b00000, 2'b00};
    tab[1] = '{1, 4 * PerVec, 1'b0, 5'b01000, 2'b01};
    tab[2] = '{2, 4 * PerVec, 1'b0, 5'b00001, 2'b00};
    tab[3] = '{0, 4 * PerVec, 1'b1, 5'b00000, 2'b00};
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {a_out, b_out, busy, done, pass, 3'b000}, 8'h00);
    chk("reset_mask_first", {1'b0, fail_mask, first_fail_vec}, 8'h00);

    // Table-driven sweeps: ideal, xor fault, and fault, ideal again after a failure
    for (int i = 0; i < 4; i++) begin
      fault = tab[i].fault;
      sweep($sformatf("vec%0d", i), tab[i].busy_cycles, -1);
      chk($sformatf("vec%0d pass", i), {7'd0, pass}, {7'd0, tab[i].pass});
      chk($sformatf("vec%0d mask", i), {3'd0, fail_mask}, {3'd0, tab[i].mask});
      if (!tab[i].pass)
        chk($sformatf("vec%0d first", i), {6'd0, first_fail_vec}, {6'd0, tab[i].first});
    end

    // Result hold while idle
    fault = 1;
    repeat (3) @(negedge clk);
    chk("hold_idle", {1'b0, pass, fail_mask, 1'b0}, {1'b0, 1'b1, 5'b00000, 1'b0});
    fault = 0;

    // start re-pulsed during vec 2 is ignored
    sweep("repulse", 4 * PerVec, 2 * PerVec + 1);
    repeat (3) @(negedge clk);
    chk("repulse_no_restart", {6'd0, busy, done}, 8'd0);

    // rst during SETTLE of vec 1
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (PerVec) @(negedge clk);
    chk("mid_vec1", {6'd0, a_out, b_out}, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid", {a_out, b_out, busy, done, pass, 3'b000}, 8'h00);
    chk("rst_mid_mask", {3'd0, fail_mask}, 8'h00);
    sweep("after_rst", 4 * PerVec, -1);
    chk("after_rst pass", {7'd0, pass}, 8'd1);

    // rst and start together: rst wins
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_beats_start", {7'd0, busy}, 8'd0);

    // start held high: next sweep begins the cycle after DONE returns to IDLE
    start = 1'b1;
    begin
      int n = 0;
      while (!done && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("held_done_seen", {7'd0, done}, 8'd1);
    end
    @(negedge clk);
    chk("held_idle_gap", {7'd0, busy}, 8'd0);
    @(negedge clk);
    chk("held_restart", {7'd0, busy}, 8'd1);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
